// File: rtl/lfsr_arb_pkg.sv
// Shared constants, FSM state type and LFSR next-state function for lfsr_rr_arbiter.
package lfsr_arb_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_RST = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[4] ^ q[3], q[4] ^ q[2], q[1], q[0], q[4]};
  endfunction

endpackage

// File: rtl/lfsr5_step.sv
// 5-bit LFSR register with enable and seed load; a zero seed is replaced by the reset value.
module lfsr5_step
  import lfsr_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  input  logic              ld,
  input  logic [LFSR_W-1:0] ld_val,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= LFSR_RST;
    end else if (ld) begin
      q <= (ld_val == '0) ? LFSR_RST : ld_val;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter sharing one 5-bit LFSR among NREQ requesters.
// Optional all-zero lockup detection on lock_err: define LFSR_LOCKUP_DET_EN.
module lfsr_rr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int STEPS = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rnd,
  output logic              busy,
  output logic              lock_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win_q;
  logic [PW-1:0]     win_c;
  logic [PW-1:0]     idx;
  logic              win_vld;
  logic [3:0]        cnt;
  logic [LFSR_W-1:0] lfsr_q;

  lfsr5_step u_lfsr (
    .clk    (clk),
    .rst_b  (rst_b),
    .en     (state == STEP),
    .ld     (seed_ld),
    .ld_val (seed),
    .q      (lfsr_q)
  );

  // First set request scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_c   = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_c   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      gnt   <= '0;
      rnd   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      win_q <= '0;
      cnt   <= '0;
    end else begin
      gnt <= '0;
      if (seed_ld) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (win_vld) begin
              win_q <= win_c;
              cnt   <= 4'(STEPS - 1);
              state <= STEP;
              busy  <= 1'b1;
            end
          end
          STEP: begin
            if (cnt == '0) begin
              // The LFSR advances on this same edge, so capture its next value.
              state <= GRANT;
              gnt   <= NREQ'(1) << win_q;
              rnd   <= lfsr_next(lfsr_q);
              ptr   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GRANT: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_LOCKUP_DET_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lock_err <= 1'b0;
    end else if (lfsr_q == '0) begin
      lock_err <= 1'b1;
    end
  end
`else
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Self-checking bench for lfsr_rr_arbiter: directed scenarios plus randomized requests/reseeds.
module tb_lfsr_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;

  logic [3:0] req1 = '0;
  logic       seed_ld1 = 1'b0;
  logic [4:0] seed1 = '0;
  logic [3:0] gnt1;
  logic [4:0] rnd1;
  logic       busy1, lock1;

  logic [3:0] req4 = '0;
  logic       seed_ld4 = 1'b0;
  logic [4:0] seed4 = '0;
  logic [3:0] gnt4;
  logic [4:0] rnd4;
  logic       busy4, lock4;

  int compared = 0;
  int mismatched = 0;

  logic [4:0] m_lfsr;
  int         m_ptr;

  always #5 clk = ~clk;

  lfsr_rr_arbiter #(.NREQ(4), .STEPS(1)) u1 (
    .clk(clk), .rst_b(rst_b), .req(req1), .seed_ld(seed_ld1), .seed(seed1),
    .gnt(gnt1), .rnd(rnd1), .busy(busy1), .lock_err(lock1)
  );

  lfsr_rr_arbiter #(.NREQ(4), .STEPS(4)) u4 (
    .clk(clk), .rst_b(rst_b), .req(req4), .seed_ld(seed_ld4), .seed(seed4),
    .gnt(gnt4), .rnd(rnd4), .busy(busy4), .lock_err(lock4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiply-by-x in GF(2^5): shift up, fold bit 4 back into taps 4,3,0.
  function automatic logic [4:0] adv(input logic [4:0] v, input int n);
    logic [4:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = (r << 1) ^ (r[4] ? 5'b11001 : 5'b00000);
    return r;
  endfunction

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (((m >> ((p + k) % 4)) & 4'b0001) != 4'b0000) return (p + k) % 4;
    return -1;
  endfunction

  task automatic wait_gnt1(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (gnt1 == '0 && lat < 40);
  endtask

  task automatic grant1(input logic [3:0] m, input int exp_lat);
    int w, lat;
    req1   = m;
    w      = pick(m, m_ptr);
    m_lfsr = adv(m_lfsr, 1);
    wait_gnt1(lat);
    chk("grant_latency", lat, exp_lat);
    chk("grant_onehot", 32'(gnt1), 32'(1) << w);
    chk("grant_rnd", 32'(rnd1), 32'(m_lfsr));
    chk("busy_in_grant", 32'(busy1), 32'(1));
    m_ptr = (w + 1) % 4;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req1 = '0; req4 = '0; seed_ld1 = 1'b0; seed_ld4 = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_rnd", 32'(rnd1), 0);
    chk("rst_lock", 32'(lock1), 0);
    chk("rst_gnt4", 32'(gnt4), 0);
    rst_b  = 1'b1;
    m_lfsr = 5'h1F;
    m_ptr  = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    #1;
    do_reset();

    // Single requester, then a second grant to the same requester
    grant1(4'b0001, 2);
    req1 = '0;
    tick();
    chk("gnt_single_cycle", 32'(gnt1), 0);
    chk("rnd_hold", 32'(rnd1), 32'h07);
    chk("busy_after_grant", 32'(busy1), 0);
    grant1(4'b0001, 2);
    chk("second_rnd_0E", 32'(rnd1), 32'h0E);
    req1 = '0;
    tick();

    // Round robin with all requesters held
    do_reset();
    grant1(4'b1111, 2);
    for (int i = 0; i < 4; i++) grant1(4'b1111, 3);
    chk("rr_last_rnd_02", 32'(rnd1), 32'h02);
    req1 = '0;
    tick();

    // Reseed in IDLE, including the zero-seed substitution
    seed_ld1 = 1'b1; seed1 = 5'h01;
    tick();
    seed_ld1 = 1'b0;
    m_lfsr = 5'h01;
    grant1(4'b0100, 2);
    chk("reseed_rnd_02", 32'(rnd1), 32'h02);
    req1 = '0;
    tick();
    seed_ld1 = 1'b1; seed1 = 5'h00;
    tick();
    seed_ld1 = 1'b0;
    m_lfsr = 5'h1F;
    grant1(4'b0100, 2);
    chk("zero_seed_rnd_07", 32'(rnd1), 32'h07);
    req1 = '0;
    tick();

    // Seed load sampled in the grant cycle
    grant1(4'b0001, 2);
    seed_ld1 = 1'b1; seed1 = 5'h0A; req1 = '0;
    tick();
    seed_ld1 = 1'b0;
    chk("seed_in_grant_gnt", 32'(gnt1), 0);
    chk("seed_in_grant_busy", 32'(busy1), 0);
    m_lfsr = 5'h0A;
    grant1(4'b0001, 2);
    req1 = '0;
    tick();

    // Async reset during GRANT and during STEP
    grant1(4'b0010, 2);
    do_reset();
    req1 = 4'b0001;
    tick();
    chk("busy_in_step", 32'(busy1), 1);
    do_reset();
    grant1(4'b0001, 2);
    chk("post_reset_rnd_07", 32'(rnd1), 32'h07);
    req1 = '0;
    tick();

    // Abort on the STEPS=4 instance: seed_ld mid-STEP discards the pending grant
    req4 = 4'b0011;
    tick();
    chk("abort_busy_step", 32'(busy4), 1);
    tick();
    seed_ld4 = 1'b1; seed4 = 5'h05;
    tick();
    seed_ld4 = 1'b0;
    chk("abort_idle_busy", 32'(busy4), 0);
    chk("abort_no_gnt", 32'(gnt4), 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (gnt4 == '0 && lat < 40);
    chk("abort_regrant_latency", lat, 5);
    chk("abort_regrant_ptr", 32'(gnt4), 32'b0001);
    chk("abort_regrant_rnd", 32'(rnd4), 32'(adv(5'h05, 4)));
    req4 = '0;
    tick();

    // Randomized requests with occasional reseeds
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [4:0] s;
        s = 5'($urandom_range(0, 31));
        seed_ld1 = 1'b1; seed1 = s;
        tick();
        seed_ld1 = 1'b0;
        m_lfsr = (s == 5'h00) ? 5'h1F : s;
      end
      grant1(4'($urandom_range(1, 15)), 2);
      req1 = '0;
      tick();
      chk("rand_gnt_single_cycle", 32'(gnt1), 0);
      chk("rand_rnd_hold", 32'(rnd1), 32'(m_lfsr));
      chk("rand_busy_idle", 32'(busy1), 0);
    end

`ifdef LFSR_LOCKUP_DET_EN
    chk("lock_clear_before", 32'(lock1), 0);
    force u1.u_lfsr.q = 5'h00;
    tick();
    release u1.u_lfsr.q;
    tick();
    chk("lock_set", 32'(lock1), 1);
    seed_ld1 = 1'b1; seed1 = 5'h03;
    tick();
    seed_ld1 = 1'b0;
    tick();
    chk("lock_sticky", 32'(lock1), 1);
`else
    chk("lock_tied_low", 32'(lock1), 0);
    chk("lock_tied_low4", 32'(lock4), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_arbiter.md
Name: lfsr_rr_arbiter

Overview:
- Shares one 5-bit LFSR random source among NREQ requesters using round-robin arbitration.
- The controller sequences the LFSR. It advances the LFSR STEPS clocks per grant for decorrelation, then hands the winner a fresh 5-bit word with a one-cycle grant.
- Supports runtime reseeding.
- Sits between the pseudo-random datapath and its consumers (test-pattern and scrambler clients).

Parameters:
- NREQ, 4, number of requesters (2..8).
- STEPS, 1, LFSR advances per grant (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset; asynchronous, active-low.
- req  input  NREQ  request per requester, level; held until its gnt bit is seen.
- seed_ld  input  1  load seed into LFSR (one-cycle pulse).
- seed  input  5  seed value.
- gnt  output  NREQ  one-hot grant, registered, high for exactly one cycle.
- rnd  output  5  random word, valid in the gnt cycle, holds its value afterwards.
- busy  output  1  high in STEP and GRANT states.
- lock_err  output  1  sticky LFSR all-zero flag (optional feature).

Behaviour:
- Reset (async, rst_b=0):
  - lfsr=5'h1F, state=IDLE.
  - gnt=0, rnd=5'h00, busy=0, ptr=0, lock_err=0.
- LFSR next state (bit i = q[i]): q0'=q4, q1'=q0, q2'=q1, q3'=q4^q2, q4'=q4^q3.
  - Sequence from 5'h1F: 1F,07,0E,1C,01,02.
- The LFSR advances only in STEP. It holds in IDLE and GRANT.
- IDLE:
  - If any req bit is set, latch winner w = first set bit scanning ptr, ptr+1, ... (mod NREQ).
  - Load step counter = STEPS-1; go to STEP.
- STEP:
  - LFSR advances each cycle.
  - When the counter reaches 0, go to GRANT; otherwise decrement.
- GRANT (one cycle):
  - gnt[w]=1; rnd = current LFSR value.
  - ptr=(w+1) mod NREQ; go to IDLE.
- Latency:
  - req seen in IDLE at cycle N -> gnt at cycle N+STEPS+1.
  - Back-to-back grants are spaced STEPS+2 cycles apart.
- The winner is latched at IDLE exit:
  - req dropping during STEP still yields the grant (protocol violation, not checked).
  - New req bits wait for the next arbitration.
- A requester that keeps req high after its gnt is re-arbitrated normally, with lowest priority.
- seed_ld (priority over all FSM transitions):
  - Next cycle: lfsr=seed, or 5'h1F if seed==0; state=IDLE.
  - The pending winner is discarded; ptr is unchanged.
  - If sampled in the GRANT cycle, the visible grant completes normally and the seed loads on the same edge as the return to IDLE.
  - If sampled in STEP, no grant is issued for that request. The requester re-arbitrates from IDLE.
- Reset mid-operation: immediate return to reset values. gnt drops asynchronously.

Optional Feature:
- Macro LFSR_LOCKUP_DET_EN.
- Defined:
  - lock_err sets when the registered lfsr==5'h00 and stays set until rst_b.
  - An all-zero LFSR can only arise from an upset; seeding never produces it.
- Undefined: lock_err is tied to 0 and no detection logic is built.

Decomposition:
- Package lfsr_arb_pkg:
  - LFSR_W=5, LFSR_RST=5'h1F.
  - State encodings IDLE=2'd0, STEP=2'd1, GRANT=2'd2.
  - The LFSR next-state function.
- Sub-module lfsr5_step holds the 5-bit LFSR register.
  - Inputs: clk, rst_b, en, ld, ld_val.
  - Output: q.
  - Zero-seed substitution is done inside it.
- The arbiter FSM, round-robin pointer and step counter stay in lfsr_rr_arbiter.

Test Plan:
- Single request: reset, STEPS=1, req=4'b0001 from cycle 2 -> gnt=4'b0001 at cycle 4 with rnd=5'h07; drop req; next req[0] grant gives rnd=5'h0E.
- Round robin: req=4'b1111 held -> grant order 0,1,2,3,0; gnt one-hot; rnd follows 07,0E,1C,01,02; spacing 3 cycles.
- Reseed: in IDLE pulse seed_ld with seed=5'h01, req[2]=1 -> gnt[2] with rnd=5'h02; seed=5'h00 -> LFSR reloads 5'h1F, next rnd=5'h07.
- Abort: seed_ld during STEP with STEPS=4 -> no gnt for that request; FSM in IDLE next cycle; ptr unchanged; held req re-granted STEPS+1 cycles after IDLE.
- Async reset mid-STEP: rst_b low between edges -> gnt=0, busy=0, rnd=0 immediately; lfsr back to 5'h1F; first post-reset grant rnd=5'h07 (STEPS=1).
- LFSR_LOCKUP_DET_EN: force lfsr to 5'h00 -> lock_err=1 and stays set through a subsequent seed_ld; without the macro, lock_err stays 0.
